// File: rtl/fifo_write_arbiter.sv
// Two-requester round-robin write arbiter feeding a single FIFO write port.
// Grants are held for up to BURST words, then handed to the other requester if it is waiting.
module fifo_write_arbiter #(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  input  logic             fifo_space_available,
  output logic             fifo_write_strobe,
  output logic [WIDTH-1:0] fifo_write_data,
  output logic [1:0]       grant,
  output logic [7:0]       burst_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT_A = 2'b01,
    GRANT_B = 2'b10
  } state_t;

  localparam logic [7:0] LAST_WORD = 8'(BURST - 1);

  state_t state;
  logic   last;  // 0 = A granted most recently, 1 = B
  logic   xfer_a, xfer_b, xfer, cur_valid, burst_done, rel;

  assign grant   = state;
  assign a_ready = state[0] & fifo_space_available;
  assign b_ready = state[1] & fifo_space_available;

  assign xfer_a = a_valid & a_ready;
  assign xfer_b = b_valid & b_ready;
  assign xfer   = xfer_a | xfer_b;

  assign fifo_write_strobe = xfer;
  assign fifo_write_data   = state[0] ? a_data : b_data;

  assign cur_valid  = state[0] ? a_valid : b_valid;
  assign burst_done = xfer && (burst_count == LAST_WORD);
  // A stalled FIFO never releases a grant by itself; only a dropped valid or a full burst does.
  assign rel        = (state != IDLE) && (!cur_valid || burst_done);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      burst_count <= 8'd0;
      last        <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          burst_count <= 8'd0;
          if (a_valid && (!b_valid || last)) begin
            state <= GRANT_A;
            last  <= 1'b0;
          end else if (b_valid) begin
            state <= GRANT_B;
            last  <= 1'b1;
          end
        end
        GRANT_A: begin
          if (rel) begin
            burst_count <= 8'd0;
            if (b_valid) begin
              state <= GRANT_B;
              last  <= 1'b1;
            end else if (a_valid) begin
              state <= GRANT_A;
              last  <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else if (xfer) begin
            burst_count <= burst_count + 8'd1;
          end
        end
        GRANT_B: begin
          if (rel) begin
            burst_count <= 8'd0;
            if (a_valid) begin
              state <= GRANT_A;
              last  <= 1'b0;
            end else if (b_valid) begin
              state <= GRANT_B;
              last  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (xfer) begin
            burst_count <= burst_count + 8'd1;
          end
        end
        default: begin
          state       <= IDLE;
          burst_count <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed and randomized checks of the two-requester FIFO write arbiter.
module tb_fifo_write_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_valid, b_valid, space;
  logic [7:0] a_data, b_data;
  logic       a_ready, b_ready, strobe;
  logic [7:0] wdata, burst;
  logic [1:0] grant;
  logic       u1_a_ready, u1_b_ready, u1_strobe;
  logic [7:0] u1_wdata, u1_burst;
  logic [1:0] u1_grant;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_write_arbiter #(.WIDTH(8), .BURST(4)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .fifo_space_available(space), .fifo_write_strobe(strobe),
    .fifo_write_data(wdata), .grant(grant), .burst_count(burst)
  );

  fifo_write_arbiter #(.WIDTH(8), .BURST(1)) u1 (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_data(a_data), .a_ready(u1_a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(u1_b_ready),
    .fifo_space_available(space), .fifo_write_strobe(u1_strobe),
    .fifo_write_data(u1_wdata), .grant(u1_grant), .burst_count(u1_burst)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [6:0] a_seq, b_seq;
  logic [6:0] exp_seq [2];
  logic       hs_a, hs_b;

  initial begin
    reset = 1'b1; a_valid = 1'b1; b_valid = 1'b1; space = 1'b1;
    a_data = 8'h00; b_data = 8'h00;
    #3;
    chk("rst_grant", grant, 2'b00);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_strobe", strobe, 0);
    chk("rst_burst", burst, 0);
    tick(); tick();
    chk("rst_hold_grant", grant, 2'b00);

    // Both valid continuously: one IDLE cycle then A,A,A,A,B,B,B,B
    reset = 1'b0;
    #1;
    chk("idle_grant", grant, 2'b00);
    chk("idle_strobe", strobe, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      a_data = 8'(i); b_data = 8'(8'h80 | i);
      #1;
      chk("rr_grant", grant, (i < 4) ? 2'b01 : 2'b10);
      chk("rr_strobe", strobe, 1);
      chk("rr_data", wdata, (i < 4) ? i : (8'h80 | i));
      chk("rr_burst", burst, i % 4);
      chk("b1_grant", u1_grant, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk("b1_burst", u1_burst, 0);
    end
    tick(); #1;
    chk("rr_wrap_grant", grant, 2'b01);
    chk("rr_wrap_burst", burst, 0);

    // A drops valid after 2 words; B takes over with a full burst
    tick(); #1;
    chk("adrop_burst1", burst, 1);
    chk("adrop_strobe1", strobe, 1);
    tick();
    a_valid = 1'b0; b_data = 8'h5B;
    #1;
    chk("adrop_grant", grant, 2'b01);
    chk("adrop_strobe", strobe, 0);
    chk("adrop_b_ready", b_ready, 0);
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      chk("bburst_grant", grant, 2'b10);
      chk("bburst_burst", burst, i);
      chk("bburst_data", wdata, 8'h5B);
      chk("bburst_strobe", strobe, 1);
    end
    tick(); #1;
    chk("bregrant_grant", grant, 2'b10);
    chk("bregrant_burst", burst, 0);

    // FIFO stalls for 3 cycles at burst_count 2
    tick(); #1;
    chk("stall_pre_burst", burst, 1);
    tick();
    space = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_strobe", strobe, 0);
      chk("stall_b_ready", b_ready, 0);
      chk("stall_grant", grant, 2'b10);
      chk("stall_burst", burst, 2);
      tick();
    end
    space = 1'b1;
    #1;
    chk("resume_burst2", burst, 2);
    chk("resume_strobe", strobe, 1);
    tick(); #1;
    chk("resume_burst3", burst, 3);
    chk("resume_strobe3", strobe, 1);
    tick(); #1;
    chk("resume_regrant", grant, 2'b10);
    chk("resume_burst0", burst, 0);

    // Move the grant to A, then pulse reset mid-grant
    b_valid = 1'b0; a_valid = 1'b1; a_data = 8'h3C;
    #1;
    chk("swap_strobe", strobe, 0);
    tick(); #1;
    chk("swap_grant", grant, 2'b01);
    chk("swap_data", wdata, 8'h3C);
    #2;
    reset = 1'b1; b_valid = 1'b1;
    #1;
    chk("midrst_grant", grant, 2'b00);
    chk("midrst_strobe", strobe, 0);
    chk("midrst_a_ready", a_ready, 0);
    chk("midrst_burst", burst, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("postrst_idle", grant, 2'b00);
    tick(); #1;
    chk("postrst_first_a", grant, 2'b01);

    // Random traffic against an in-order FIFO scoreboard
    a_seq = 7'd0; b_seq = 7'd0; exp_seq[0] = 7'd0; exp_seq[1] = 7'd0;
    hs_a = 1'b0; hs_b = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (hs_a) a_seq = a_seq + 7'd1;
      if (hs_b) b_seq = b_seq + 7'd1;
      if (hs_a || !a_valid) a_valid = 1'($urandom_range(0, 1));
      if (hs_b || !b_valid) b_valid = 1'($urandom_range(0, 1));
      space  = ($urandom_range(0, 3) != 0);
      a_data = {1'b0, a_seq};
      b_data = {1'b1, b_seq};
      #1;
      hs_a = a_valid & a_ready;
      hs_b = b_valid & b_ready;
      if (strobe) begin
        chk("rnd_space", space, 1);
        chk("rnd_order", wdata[6:0], exp_seq[wdata[7]]);
        exp_seq[wdata[7]] = exp_seq[wdata[7]] + 7'd1;
      end
      if (!space) chk("rnd_nowrite", strobe, 0);
      tick();
    end
    if (hs_a) a_seq = a_seq + 7'd1;
    if (hs_b) b_seq = b_seq + 7'd1;
    a_valid = 1'b0; b_valid = 1'b0;
    chk("rnd_count_a", exp_seq[0], a_seq);
    chk("rnd_count_b", exp_seq[1], b_seq);
    tick(); tick(); #1;
    chk("rnd_final_idle", grant, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
